// File: rtl/cond_check_stage.sv
// -----------------------------------------------------------------------------
// cond_check_stage
//
// Condition-check pipeline stage placed directly after the status
// (condition-code) register. It evaluates the 4-bit ARM condition field of the
// decoded instruction against the current {N,Z,C,V} flags and registers the
// pass/branch decision for the next stage.
//
// The flags come from the EX-stage forward when that instruction sets flags and
// its flags are final. Otherwise they come from the status register. When the
// EX instruction will set flags but they are not final yet, the stage parks the
// instruction in WAIT and asserts hazard_stall. It leaves WAIT when the
// forwarded flags arrive, or after WAIT_MAX cycles. By then the status register
// holds the new flags.
//
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   cond_in       condition field of the decoded instruction
//   instr_valid   cond_in / is_branch valid this cycle
//   is_branch     instruction is a branch
//   cc_reg        {N,Z,C,V} from the status register
//   cc_fwd        {N,Z,C,V} produced by the EX-stage instruction
//   S_fwd         EX-stage instruction will set flags
//   fwd_valid     cc_fwd holds final values this cycle
//   stall_in      downstream stall, all outputs hold
//   flush         kill the instruction in this stage
//   valid_out     registered result valid
//   cond_pass     condition satisfied
//   branch_taken  cond_pass & is_branch
//   cond_out      condition field of the result
//   cc_used       flags used for the evaluation
//   hazard_stall  stage is in WAIT, upstream must hold
// -----------------------------------------------------------------------------
module cond_check_stage #(
    parameter int WAIT_MAX = 4,
    parameter int CNT_W    = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] cond_in,
    input  logic       instr_valid,
    input  logic       is_branch,
    input  logic [3:0] cc_reg,
    input  logic [3:0] cc_fwd,
    input  logic       S_fwd,
    input  logic       fwd_valid,
    input  logic       stall_in,
    input  logic       flush,
    output logic       valid_out,
    output logic       cond_pass,
    output logic       branch_taken,
    output logic [3:0] cond_out,
    output logic [3:0] cc_used,
    output logic       hazard_stall
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             pass_q, pass_d;
    logic             br_q, br_d;
    logic [3:0]       cond_out_q, cond_out_d;
    logic [3:0]       cc_used_q, cc_used_d;
    logic [3:0]       hold_cond_q, hold_cond_d;
    logic             hold_br_q, hold_br_d;
    logic [3:0]       flag_hold_q, flag_hold_d;
    logic             flags_ready_q, flags_ready_d;

    // Condition table, cc = {N,Z,C,V}.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] cc);
        logic n, z, c, v;
        logic r;
        n = cc[3];
        z = cc[2];
        c = cc[1];
        v = cc[0];
        case (cond)
            4'b0000: r = z;
            4'b0001: r = !z;
            4'b0010: r = c;
            4'b0011: r = !c;
            4'b0100: r = n;
            4'b0101: r = !n;
            4'b0110: r = v;
            4'b0111: r = !v;
            4'b1000: r = c & !z;
            4'b1001: r = !c | z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = !z & (n == v);
            4'b1101: r = z | (n != v);
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic       needs_flags;
    logic [3:0] cc_eff;
    logic       hazard;
    logic       run_pass;
    logic [3:0] wait_cc;
    logic       wait_pass;

    // AL (1110) and NV (1111) ignore the flags, so they never wait.
    assign needs_flags = (cond_in[3:1] != 3'b111);
    assign cc_eff      = (S_fwd & fwd_valid) ? cc_fwd : cc_reg;
    assign hazard      = instr_valid & needs_flags & S_fwd & !fwd_valid;
    assign run_pass    = cond_eval(cond_in, cc_eff);

    // Flags captured during a downstream stall take precedence. They are the
    // final forwarded values, and the forward may already be gone by now.
    always_comb begin
        wait_cc = cc_reg;
        if (flags_ready_q) begin
            wait_cc = flag_hold_q;
        end else if (fwd_valid) begin
            wait_cc = cc_fwd;
        end
    end
    assign wait_pass = cond_eval(hold_cond_q, wait_cc);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        valid_d       = valid_q;
        pass_d        = pass_q;
        br_d          = br_q;
        cond_out_d    = cond_out_q;
        cc_used_d     = cc_used_q;
        hold_cond_d   = hold_cond_q;
        hold_br_d     = hold_br_q;
        flag_hold_d   = flag_hold_q;
        flags_ready_d = flags_ready_q;

        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    valid_d = 1'b0;
                end else if (stall_in) begin
                    // hold everything
                end else if (instr_valid && hazard) begin
                    hold_cond_d   = cond_in;
                    hold_br_d     = is_branch;
                    valid_d       = 1'b0;
                    cnt_d         = '0;
                    flags_ready_d = 1'b0;
                    state_d       = ST_WAIT;
                end else if (instr_valid) begin
                    cond_out_d = cond_in;
                    cc_used_d  = cc_eff;
                    pass_d     = run_pass;
                    br_d       = run_pass & is_branch;
                    valid_d    = 1'b1;
                end else begin
                    valid_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    valid_d       = 1'b0;
                    flags_ready_d = 1'b0;
                    state_d       = ST_RUN;
                end else if (stall_in) begin
                    // The forward may drop before the stall clears, so keep a copy.
                    if (fwd_valid) begin
                        flag_hold_d   = cc_fwd;
                        flags_ready_d = 1'b1;
                    end
                end else if (flags_ready_q || fwd_valid || (cnt_q == CNT_LAST)) begin
                    // On timeout the status register already holds the new
                    // flags, so wait_cc falls back to cc_reg.
                    cond_out_d    = hold_cond_q;
                    cc_used_d     = wait_cc;
                    pass_d        = wait_pass;
                    br_d          = wait_pass & hold_br_q;
                    valid_d       = 1'b1;
                    flags_ready_d = 1'b0;
                    state_d       = ST_RUN;
                end else begin
                    if (cnt_q != CNT_LAST) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_RUN;
            cnt_q         <= '0;
            valid_q       <= 1'b0;
            pass_q        <= 1'b0;
            br_q          <= 1'b0;
            cond_out_q    <= 4'b0;
            cc_used_q     <= 4'b0;
            hold_cond_q   <= 4'b0;
            hold_br_q     <= 1'b0;
            flag_hold_q   <= 4'b0;
            flags_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            valid_q       <= valid_d;
            pass_q        <= pass_d;
            br_q          <= br_d;
            cond_out_q    <= cond_out_d;
            cc_used_q     <= cc_used_d;
            hold_cond_q   <= hold_cond_d;
            hold_br_q     <= hold_br_d;
            flag_hold_q   <= flag_hold_d;
            flags_ready_q <= flags_ready_d;
        end
    end

    assign valid_out    = valid_q;
    assign cond_pass    = pass_q;
    assign branch_taken = br_q;
    assign cond_out     = cond_out_q;
    assign cc_used      = cc_used_q;
    assign hazard_stall = (state_q == ST_WAIT);

endmodule

// File: tb/tb_cond_check_stage.sv
module tb_cond_check_stage;

    logic       CLK;
    logic       RST;
    logic [3:0] cond_in;
    logic       instr_valid;
    logic       is_branch;
    logic [3:0] cc_reg;
    logic [3:0] cc_fwd;
    logic       S_fwd;
    logic       fwd_valid;
    logic       stall_in;
    logic       flush;
    logic       valid_out;
    logic       cond_pass;
    logic       branch_taken;
    logic [3:0] cond_out;
    logic [3:0] cc_used;
    logic       hazard_stall;

    int checks_q;
    int errors_q;

    cond_check_stage #(
        .WAIT_MAX(4),
        .CNT_W   (4)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .cond_in     (cond_in),
        .instr_valid (instr_valid),
        .is_branch   (is_branch),
        .cc_reg      (cc_reg),
        .cc_fwd      (cc_fwd),
        .S_fwd       (S_fwd),
        .fwd_valid   (fwd_valid),
        .stall_in    (stall_in),
        .flush       (flush),
        .valid_out   (valid_out),
        .cond_pass   (cond_pass),
        .branch_taken(branch_taken),
        .cond_out    (cond_out),
        .cc_used     (cc_used),
        .hazard_stall(hazard_stall)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks_q++;
        if (got !== exp) begin
            errors_q++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step(input string name);
        @(posedge CLK);
        #1;
        $display("[%0t] %-12s valid=%0b pass=%0b br=%0b cond=%b cc=%b hz=%0b",
                 $time, name, valid_out, cond_pass, branch_taken, cond_out, cc_used, hazard_stall);
    endtask

    // Checks the full result: valid, pass, branch, cond_out, cc_used, hazard_stall.
    task automatic expect_res(input string tag, input logic v, input logic p, input logic b,
                              input logic [3:0] c, input logic [3:0] cc, input logic hz);
        check({tag, ".valid"}, {7'b0, valid_out}, {7'b0, v});
        check({tag, ".pass"},  {7'b0, cond_pass}, {7'b0, p});
        check({tag, ".br"},    {7'b0, branch_taken}, {7'b0, b});
        check({tag, ".cond"},  {4'b0, cond_out}, {4'b0, c});
        check({tag, ".cc"},    {4'b0, cc_used}, {4'b0, cc});
        check({tag, ".hz"},    {7'b0, hazard_stall}, {7'b0, hz});
    endtask

    task automatic idle_inputs();
        cond_in     = 4'b0;
        instr_valid = 1'b0;
        is_branch   = 1'b0;
        cc_reg      = 4'b0;
        cc_fwd      = 4'b0;
        S_fwd       = 1'b0;
        fwd_valid   = 1'b0;
        stall_in    = 1'b0;
        flush       = 1'b0;
    endtask

    // Direct-evaluation vectors: cond, cc_reg, is_branch, expected pass.
    typedef struct {
        logic [3:0] cond;
        logic [3:0] cc;
        logic       br;
        logic       pass;
    } vec_t;

    vec_t vecs[8];

    initial begin
        checks_q = 0;
        errors_q = 0;
        vecs[0] = '{4'b0000, 4'b0100, 1'b1, 1'b1};  // EQ, Z=1
        vecs[1] = '{4'b1011, 4'b1000, 1'b1, 1'b1};  // LT, N!=V
        vecs[2] = '{4'b1111, 4'b1111, 1'b1, 1'b0};  // NV
        vecs[3] = '{4'b1110, 4'b0000, 1'b0, 1'b1};  // AL
        vecs[4] = '{4'b1100, 4'b0000, 1'b1, 1'b1};  // GT, !Z & N==V
        vecs[5] = '{4'b1001, 4'b0010, 1'b1, 1'b0};  // LS, C=1 Z=0
        vecs[6] = '{4'b1000, 4'b0010, 1'b1, 1'b1};  // HI
        vecs[7] = '{4'b1101, 4'b1001, 1'b0, 1'b0};  // LE, Z=0 N==V

        // Reset with arbitrary inputs.
        idle_inputs();
        RST         = 1'b1;
        cond_in     = 4'b0101;
        instr_valid = 1'b1;
        is_branch   = 1'b1;
        cc_reg      = 4'b1111;
        S_fwd       = 1'b1;
        step("reset1");
        step("reset2");
        expect_res("reset", 1'b0, 1'b0, 1'b0, 4'b0, 4'b0, 1'b0);
        RST = 1'b0;
        idle_inputs();

        // Direct evaluation from the status register.
        for (int i = 0; i < 8; i++) begin
            cond_in     = vecs[i].cond;
            cc_reg      = vecs[i].cc;
            is_branch   = vecs[i].br;
            instr_valid = 1'b1;
            step("direct");
            expect_res($sformatf("direct%0d", i), 1'b1, vecs[i].pass,
                       vecs[i].pass & vecs[i].br, vecs[i].cond, vecs[i].cc, 1'b0);
        end

        // AL/NV with a pending flag-setter must not stall.
        cond_in = 4'b1111; cc_reg = 4'b1000; S_fwd = 1'b1; fwd_valid = 1'b0; is_branch = 1'b1;
        step("nv_sfwd");
        expect_res("nv_sfwd", 1'b1, 1'b0, 1'b0, 4'b1111, 4'b1000, 1'b0);
        cond_in = 4'b1110;
        step("al_sfwd");
        expect_res("al_sfwd", 1'b1, 1'b1, 1'b1, 4'b1110, 4'b1000, 1'b0);

        // Forwarded flags override the status register.
        cond_in = 4'b0000; cc_reg = 4'b0100; cc_fwd = 4'b0000; S_fwd = 1'b1; fwd_valid = 1'b1;
        step("fwd");
        expect_res("fwd", 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);

        // Idle cycle drops valid.
        idle_inputs();
        step("idle");
        check("idle.valid", {7'b0, valid_out}, 8'd0);

        // Hazard, a second instruction ignored, forward arrives two cycles later.
        cond_in = 4'b0001; instr_valid = 1'b1; is_branch = 1'b1; cc_reg = 4'b0100;
        S_fwd = 1'b1; fwd_valid = 1'b0;
        step("hz_enter");
        check("hz_enter.hz", {7'b0, hazard_stall}, 8'd1);
        check("hz_enter.valid", {7'b0, valid_out}, 8'd0);
        cond_in = 4'b0000; is_branch = 1'b0;
        step("hz_other");
        check("hz_other.hz", {7'b0, hazard_stall}, 8'd1);
        check("hz_other.valid", {7'b0, valid_out}, 8'd0);
        instr_valid = 1'b0; fwd_valid = 1'b1; cc_fwd = 4'b0000;
        step("hz_fwd");
        expect_res("hz_fwd", 1'b1, 1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0);
        idle_inputs();
        step("hz_after");
        check("hz_after.valid", {7'b0, valid_out}, 8'd0);

        // Timeout: result exactly 4 cycles after entering WAIT, using cc_reg.
        cond_in = 4'b0000; instr_valid = 1'b1; cc_reg = 4'b0100; S_fwd = 1'b1;
        step("to_enter");
        check("to_enter.hz", {7'b0, hazard_stall}, 8'd1);
        instr_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            step("to_wait");
            check($sformatf("to_wait%0d.valid", i), {7'b0, valid_out}, 8'd0);
            check($sformatf("to_wait%0d.hz", i), {7'b0, hazard_stall}, 8'd1);
        end
        step("to_exit");
        expect_res("to_exit", 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0100, 1'b0);
        idle_inputs();
        step("idle");

        // Flush during WAIT beats a simultaneous forward.
        cond_in = 4'b0000; instr_valid = 1'b1; S_fwd = 1'b1;
        step("fl_enter");
        check("fl_enter.hz", {7'b0, hazard_stall}, 8'd1);
        instr_valid = 1'b0; flush = 1'b1; fwd_valid = 1'b1; cc_fwd = 4'b0100;
        step("fl_flush");
        check("fl_flush.valid", {7'b0, valid_out}, 8'd0);
        check("fl_flush.hz", {7'b0, hazard_stall}, 8'd0);
        idle_inputs();
        step("fl_after");
        check("fl_after.valid", {7'b0, valid_out}, 8'd0);

        // Stall in WAIT captures the forward; the exit uses the captured flags.
        cond_in = 4'b0000; instr_valid = 1'b1; cc_reg = 4'b0000; S_fwd = 1'b1;
        step("sc_enter");
        instr_valid = 1'b0; stall_in = 1'b1; fwd_valid = 1'b1; cc_fwd = 4'b0100;
        step("sc_stall");
        check("sc_stall.hz", {7'b0, hazard_stall}, 8'd1);
        check("sc_stall.valid", {7'b0, valid_out}, 8'd0);
        stall_in = 1'b0; fwd_valid = 1'b0; cc_fwd = 4'b0000; S_fwd = 1'b0;
        step("sc_exit");
        expect_res("sc_exit", 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0100, 1'b0);

        // Stall after a valid result holds the outputs for 3 cycles.
        idle_inputs();
        cond_in = 4'b0000; instr_valid = 1'b1; is_branch = 1'b1; cc_reg = 4'b0100;
        step("st_res");
        expect_res("st_res", 1'b1, 1'b1, 1'b1, 4'b0000, 4'b0100, 1'b0);
        stall_in = 1'b1; cond_in = 4'b1111; cc_reg = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step("st_hold");
            expect_res($sformatf("st_hold%0d", i), 1'b1, 1'b1, 1'b1, 4'b0000, 4'b0100, 1'b0);
        end
        idle_inputs();

        // Flush in RUN suppresses a valid instruction.
        cond_in = 4'b1110; instr_valid = 1'b1; flush = 1'b1;
        step("fl_run");
        check("fl_run.valid", {7'b0, valid_out}, 8'd0);
        idle_inputs();

        // Reset in the middle of WAIT discards the held instruction.
        cond_in = 4'b0000; instr_valid = 1'b1; S_fwd = 1'b1;
        step("rw_enter");
        check("rw_enter.hz", {7'b0, hazard_stall}, 8'd1);
        instr_valid = 1'b0; RST = 1'b1;
        step("rw_reset");
        expect_res("rw_reset", 1'b0, 1'b0, 1'b0, 4'b0, 4'b0, 1'b0);
        RST = 1'b0; fwd_valid = 1'b1; cc_fwd = 4'b0100;
        step("rw_after");
        check("rw_after.valid", {7'b0, valid_out}, 8'd0);
        check("rw_after.hz", {7'b0, hazard_stall}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors_q, checks_q);
        $finish;
    end

endmodule

// File: doc/cond_check_stage.md
Name: cond_check_stage

Overview:
Condition-check pipeline stage that sits directly downstream of the status (condition-code) register. It evaluates the 4-bit ARM condition field of the decoded instruction against the current flags. Flags come either from the status register output or from flags being forwarded by the instruction in EX that has its S bit set. It registers the pass/branch decision for the next stage, and stalls when the forwarded flags are not ready yet.

Parameters:
WAIT_MAX, 4, maximum cycles spent in WAIT before falling back to the status-register flags (1..15).
CNT_W, 4, width of the wait counter; must hold WAIT_MAX.

Ports:
CLK  input  1  clock; all state updates on posedge
RST  input  1  synchronous, active-high reset
cond_in  input  4  condition field of the decoded instruction
instr_valid  input  1  cond_in/is_branch valid this cycle
is_branch  input  1  instruction is a branch
cc_reg  input  4  flags {N,Z,C,V} from the status register output
cc_fwd  input  4  flags {N,Z,C,V} produced by the EX-stage instruction
S_fwd  input  1  EX-stage instruction will set flags
fwd_valid  input  1  cc_fwd holds final values this cycle
stall_in  input  1  downstream stall; hold all outputs
flush  input  1  kill the instruction in this stage
valid_out  output  1  registered result valid
cond_pass  output  1  condition satisfied
branch_taken  output  1  cond_pass & held is_branch
cond_out  output  4  condition field of the result
cc_used  output  4  flags used for the evaluation
hazard_stall  output  1  stage is in WAIT; upstream must hold

Behaviour:
- Reset (RST=1 at posedge): state=RUN, wait counter=0, all outputs 0, hold registers 0.
- Reset mid-WAIT behaves identically: the held instruction is discarded.
- Flag mapping: cc[3]=N, cc[2]=Z, cc[1]=C, cc[0]=V.
- Condition table:
  - 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V
  - 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V
  - 1100 !Z&(N==V); 1101 Z|(N!=V); 1110 AL=1; 1111 NV=0
- needs_flags = cond_in not in {1110,1111}.
- Effective flags: cc_fwd if S_fwd&fwd_valid, else cc_reg.
- hazard = instr_valid & needs_flags & S_fwd & !fwd_valid.
- hazard_stall = (state==WAIT). It is a registered state decode, not combinational on the inputs.
- Priority at each posedge: RST > flush > stall_in > state action.
- RUN state:
  - flush: valid_out<=0; stay RUN.
  - stall_in: all outputs and state hold.
  - instr_valid & hazard: latch cond_in and is_branch into hold regs; valid_out<=0; counter<=0; go WAIT.
  - instr_valid & !hazard: register cond_out, cc_used, cond_pass, branch_taken; valid_out<=1.
  - otherwise: valid_out<=0.
  - Latency is 1 cycle, input to registered output.
- WAIT state:
  - instr_valid is ignored.
  - flush: valid_out<=0; go RUN.
  - fwd_valid & !stall_in: evaluate held cond with cc_fwd; valid_out<=1; go RUN.
  - fwd_valid & stall_in: capture cc_fwd into a flag-hold register and set flags_ready; stay WAIT; later exit uses the captured flags.
  - counter==WAIT_MAX-1 & !fwd_valid & !stall_in: evaluate with cc_reg (the status register has been written by then); go RUN.
  - otherwise: counter++, saturating at WAIT_MAX-1; valid_out<=0.
- Flush and fwd_valid in the same cycle: flush wins and no result is produced.
- AL/NV never enter WAIT, even while S_fwd=1.

Test Plan:
- Reset: RST=1 for 2 cycles with arbitrary inputs -> all outputs 0, hazard_stall=0.
- Direct eval: cc_reg=0100, cond_in=0000, is_branch=1, S_fwd=0 -> next cycle valid_out=1, cond_pass=1, branch_taken=1, cc_used=0100. Repeat with cond 1011, cc_reg=1000 -> pass=1; with 1111 -> pass=0.
- Forward override: cc_reg=0100, cc_fwd=0000, S_fwd=1, fwd_valid=1, cond 0000 -> cond_pass=0, cc_used=0000.
- Hazard: cond 0001, S_fwd=1, fwd_valid=0 -> hazard_stall=1 next cycle. Raise fwd_valid with cc_fwd=0000 two cycles later -> valid_out=1, cond_pass=1 the cycle after, then hazard_stall=0. A different instr_valid presented during WAIT is not evaluated.
- Timeout: hazard with fwd_valid never raised, cc_reg=0100, cond 0000, WAIT_MAX=4 -> result emitted exactly WAIT_MAX cycles after entering WAIT, cond_pass=1.
- Flush/stall: flush during WAIT with fwd_valid=1 -> valid_out=0, state RUN. stall_in held for 3 cycles after a valid result -> outputs unchanged across those cycles.
